// File: rtl/mm_output_packer.sv
// mm_output_packer
//
// Packs leftmost-aligned matmul output rows into dense activation-buffer write words. Each
// accepted row carries count_i valid leading elements that are appended to a staging buffer. Full
// words leave the buffer head over a valid/ready write port at auto-incrementing addresses. The
// final row of a tile (last_i) triggers a flush of any partial word and a one-cycle done_o pulse.
//
// Ports:
//   clk          clock, all state on rising edge
//   nrst         asynchronous reset, active-high
//   start_i      begin a tile (IDLE only); base_addr_i sampled with it
//   valid_i      input row valid; ready_o = packer accepts a row this cycle
//   data_i       aligned row, element 0 in the most significant slice
//   count_i      number of valid leading elements, clamped to numElements
//   last_i       row is the final one of the tile, sampled on accept
//   wr_valid_o   write word valid; wr_ready_i = buffer accepts the word
//   wr_addr_o    write address
//   wr_data_o    write word, element 0 in the least significant slice
//   done_o       one-cycle pulse at tile completion

module mm_output_packer #(
  parameter int unsigned elementBits  = 8,
  parameter int unsigned numElements  = 256,
  parameter int unsigned wordElements = 32,
  parameter int unsigned addrWidth    = 16
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic                                start_i,
  input  logic [addrWidth-1:0]                base_addr_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic [numElements*elementBits-1:0]  data_i,
  input  logic [$clog2(numElements):0]        count_i,
  input  logic                                last_i,
  output logic                                wr_valid_o,
  input  logic                                wr_ready_i,
  output logic [addrWidth-1:0]                wr_addr_o,
  output logic [wordElements*elementBits-1:0] wr_data_o,
  output logic                                done_o
);

  localparam int unsigned CntW     = $clog2(numElements) + 1;
  localparam int unsigned BufElems = wordElements + numElements - 1;
  localparam int unsigned BufBits  = BufElems * elementBits;
  localparam int unsigned RowBits  = numElements * elementBits;
  localparam int unsigned WordBits = wordElements * elementBits;
  localparam int unsigned FillW    = $clog2(BufElems + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [BufBits-1:0]   r_buf;
  logic [BufBits-1:0]   w_buf_next;
  logic [FillW-1:0]     r_fill;
  logic [FillW-1:0]     w_fill_next;
  logic [addrWidth-1:0] r_addr;
  logic [addrWidth-1:0] w_addr_next;

  logic [CntW-1:0]      w_cnt;
  logic [RowBits-1:0]   w_row;
  logic [BufBits-1:0]   w_ins;
  logic                 w_accept;
  logic                 w_emit;

  // ---------------------------------------------------------------------------------------------
  // Input row conditioning
  // ---------------------------------------------------------------------------------------------
  assign w_cnt = (count_i > CntW'(numElements)) ? CntW'(numElements) : count_i;

  // Reverse to element-0-lowest order and zero everything past the valid count, so the row can be
  // OR-ed into the buffer: slots at and above fill are always zero.
  always_comb begin
    w_row = '0;
    for (int unsigned i = 0; i < numElements; i++) begin
      if (i < 32'(w_cnt)) begin
        w_row[i*elementBits +: elementBits] = data_i[(numElements-1-i)*elementBits +: elementBits];
      end
    end
  end

  // Accept only happens with fill < wordElements, so the shifted row always fits the buffer.
  assign w_ins = BufBits'(w_row) << (32'(r_fill) * elementBits);

  assign w_accept = valid_i & ready_o;
  assign w_emit   = wr_valid_o & wr_ready_i;

  // ---------------------------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (start_i) w_state_next = StRun;
      end
      StRun: begin
        if (w_accept && last_i) w_state_next = StFlush;
      end
      StFlush: begin
        if (r_fill == '0) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: outputs (registered state only, no input-to-output paths)
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    ready_o    = 1'b0;
    wr_valid_o = 1'b0;
    done_o     = 1'b0;
    case (r_state)
      StRun: begin
        ready_o    = (r_fill < FillW'(wordElements));
        wr_valid_o = (r_fill >= FillW'(wordElements));
      end
      StFlush: begin
        wr_valid_o = (r_fill != '0);
        done_o     = (r_fill == '0);
      end
      default: ;
    endcase
  end

  // Slots beyond fill are held at zero, so a partial flush word is already zero-padded.
  assign wr_addr_o = r_addr;
  assign wr_data_o = r_buf[WordBits-1:0];

  // ---------------------------------------------------------------------------------------------
  // Datapath: staging buffer, fill level, write address
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    w_buf_next  = r_buf;
    w_fill_next = r_fill;
    w_addr_next = r_addr;
    if (r_state == StIdle) begin
      if (start_i) begin
        w_buf_next  = '0;
        w_fill_next = '0;
        w_addr_next = base_addr_i;
      end
    end else if (w_accept) begin
      w_buf_next  = r_buf | w_ins;
      w_fill_next = r_fill + FillW'(w_cnt);
    end else if (w_emit) begin
      // Accept and emit never coincide: they need opposite sides of the fill threshold.
      w_buf_next  = r_buf >> WordBits;
      w_fill_next = (r_fill > FillW'(wordElements)) ? (r_fill - FillW'(wordElements)) : '0;
      w_addr_next = r_addr + addrWidth'(1);
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_buf  <= '0;
      r_fill <= '0;
      r_addr <= '0;
    end else begin
      r_buf  <= w_buf_next;
      r_fill <= w_fill_next;
      r_addr <= w_addr_next;
    end
  end

endmodule

// File: tb/tb_mm_output_packer.sv
module tb_mm_output_packer;

  logic            clk;
  logic            nrst;
  logic            start_i;
  logic [15:0]     base_addr_i;
  logic            valid_i;
  logic            ready_o;
  logic [2047:0]   data_i;
  logic [8:0]      count_i;
  logic            last_i;
  logic            wr_valid_o;
  logic            wr_ready_i;
  logic [15:0]     wr_addr_o;
  logic [255:0]    wr_data_o;
  logic            done_o;

  mm_output_packer #(
    .elementBits (8),
    .numElements (256),
    .wordElements(32),
    .addrWidth   (16)
  ) u_dut (
    .clk        (clk),
    .nrst       (nrst),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_i     (data_i),
    .count_i    (count_i),
    .last_i     (last_i),
    .wr_valid_o (wr_valid_o),
    .wr_ready_i (wr_ready_i),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .done_o     (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  logic [15:0]  q_addr[$];
  logic [255:0] q_data[$];

  // Record completed write transfers and done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (!nrst) begin
      if (wr_valid_o && wr_ready_i) begin
        q_addr.push_back(wr_addr_o);
        q_data.push_back(wr_data_o);
      end
      if (done_o) done_cnt = done_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Element i = seed + i, placed with element 0 in the most significant slice.
  function automatic logic [2047:0] make_row(input logic [7:0] seed);
    logic [2047:0] r;
    for (int i = 0; i < 256; i++) r[(255-i)*8 +: 8] = seed + 8'(i);
    return r;
  endfunction

  // Word whose slot j holds start + j.
  function automatic logic [255:0] seq_word(input logic [7:0] start);
    logic [255:0] w;
    for (int j = 0; j < 32; j++) w[j*8 +: 8] = start + 8'(j);
    return w;
  endfunction

  task automatic do_start(input logic [15:0] base);
    start_i     = 1'b1;
    base_addr_i = base;
    tick();
    start_i     = 1'b0;
  endtask

  task automatic send_row(input logic [2047:0] d, input logic [8:0] cnt, input logic lst);
    int n;
    valid_i = 1'b1;
    data_i  = d;
    count_i = cnt;
    last_i  = lst;
    n = 0;
    while (!ready_o && n < 50) begin
      tick();
      n++;
    end
    check("row_ready", {255'b0, ready_o}, 256'd1);
    tick();
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic wait_done(output int waited);
    waited = 0;
    while (!done_o && waited < 100) begin
      tick();
      waited++;
    end
    check("done_pulse", {255'b0, done_o}, 256'd1);
    tick();
    check("done_one_cycle", {255'b0, done_o}, 256'd0);
    check("idle_no_write", {255'b0, wr_valid_o}, 256'd0);
  endtask

  int           waited;
  int           d0;
  logic [255:0] e;
  logic [15:0]  a0;
  logic [255:0] w0;

  initial begin
    nrst        = 1'b1;
    start_i     = 1'b0;
    base_addr_i = '0;
    valid_i     = 1'b0;
    data_i      = '0;
    count_i     = '0;
    last_i      = 1'b0;
    wr_ready_i  = 1'b0;
    #3;
    check("rst_ready", {255'b0, ready_o}, 256'd0);
    check("rst_wr_valid", {255'b0, wr_valid_o}, 256'd0);
    check("rst_done", {255'b0, done_o}, 256'd0);
    check("rst_addr", {240'b0, wr_addr_o}, 256'd0);
    check("rst_data", wr_data_o, 256'd0);
    tick();
    tick();
    nrst = 1'b0;
    tick();
    check("idle_ready", {255'b0, ready_o}, 256'd0);

    // Full row, eight words
    wr_ready_i = 1'b1;
    do_start(16'h0100);
    check("run_ready", {255'b0, ready_o}, 256'd1);
    send_row(make_row(8'h00), 9'd256, 1'b1);
    wait_done(waited);
    check("t1_latency", 256'(waited), 256'd8);
    check("t1_nwords", 256'(q_addr.size()), 256'd8);
    for (int k = 0; k < 8 && k < q_addr.size(); k++) begin
      check("t1_addr", {240'b0, q_addr[k]}, 256'(16'h0100 + k));
      check("t1_data", q_data[k], seq_word(8'(32 * k)));
    end
    check("t1_done_cnt", 256'(done_cnt), 256'd1);
    q_addr.delete();
    q_data.delete();

    // 20 + 20 + 24 elements
    do_start(16'h0200);
    send_row(make_row(8'h00), 9'd20, 1'b0);
    send_row(make_row(8'h40), 9'd20, 1'b0);
    check("t2_full_ready", {255'b0, ready_o}, 256'd0);
    check("t2_full_valid", {255'b0, wr_valid_o}, 256'd1);
    send_row(make_row(8'h80), 9'd24, 1'b1);
    wait_done(waited);
    check("t2_nwords", 256'(q_addr.size()), 256'd2);
    for (int j = 0; j < 32; j++) e[j*8 +: 8] = (j < 20) ? 8'(j) : 8'(8'h40 + j - 20);
    if (q_addr.size() > 0) begin
      check("t2_addr0", {240'b0, q_addr[0]}, 256'h0200);
      check("t2_data0", q_data[0], e);
    end
    for (int j = 0; j < 32; j++) e[j*8 +: 8] = (j < 8) ? 8'(8'h4C + j) : 8'(8'h80 + j - 8);
    if (q_addr.size() > 1) begin
      check("t2_addr1", {240'b0, q_addr[1]}, 256'h0201);
      check("t2_data1", q_data[1], e);
    end
    q_addr.delete();
    q_data.delete();

    // 40 elements: one full word plus a zero-padded partial word
    do_start(16'h0300);
    send_row(make_row(8'h20), 9'd40, 1'b1);
    wait_done(waited);
    check("t3_nwords", 256'(q_addr.size()), 256'd2);
    e = '0;
    for (int j = 0; j < 8; j++) e[j*8 +: 8] = 8'(8'h40 + j);
    if (q_addr.size() > 1) begin
      check("t3_data0", q_data[0], seq_word(8'h20));
      check("t3_data1", q_data[1], e);
      check("t3_addr1", {240'b0, q_addr[1]}, 256'h0301);
    end
    q_addr.delete();
    q_data.delete();

    // Backpressure mid-tile, with address wrap
    wr_ready_i = 1'b0;
    do_start(16'hFFFF);
    send_row(make_row(8'hA0), 9'd40, 1'b0);
    a0 = wr_addr_o;
    w0 = wr_data_o;
    check("t4_stall_addr0", {240'b0, a0}, 256'hFFFF);
    for (int c = 0; c < 5; c++) begin
      check("t4_stall_valid", {255'b0, wr_valid_o}, 256'd1);
      check("t4_stall_ready", {255'b0, ready_o}, 256'd0);
      check("t4_stall_addr", {240'b0, wr_addr_o}, {240'b0, a0});
      check("t4_stall_data", wr_data_o, w0);
      tick();
    end
    wr_ready_i = 1'b1;
    send_row(make_row(8'h10), 9'd56, 1'b1);
    wait_done(waited);
    check("t4_nwords", 256'(q_addr.size()), 256'd3);
    for (int j = 0; j < 32; j++) e[j*8 +: 8] = (j < 8) ? 8'(8'hC0 + j) : 8'(8'h10 + j - 8);
    if (q_addr.size() > 2) begin
      check("t4_data0", q_data[0], seq_word(8'hA0));
      check("t4_data1", q_data[1], e);
      check("t4_data2", q_data[2], seq_word(8'h28));
      check("t4_addr1", {240'b0, q_addr[1]}, 256'h0000);
      check("t4_addr2", {240'b0, q_addr[2]}, 256'h0001);
    end
    q_addr.delete();
    q_data.delete();

    // Reset during flush
    wr_ready_i = 1'b0;
    do_start(16'h0400);
    send_row(make_row(8'h55), 9'd40, 1'b1);
    check("t5_flush_valid", {255'b0, wr_valid_o}, 256'd1);
    d0 = done_cnt;
    nrst = 1'b1;
    #1;
    check("t5_rst_ready", {255'b0, ready_o}, 256'd0);
    check("t5_rst_valid", {255'b0, wr_valid_o}, 256'd0);
    check("t5_rst_done", {255'b0, done_o}, 256'd0);
    check("t5_rst_addr", {240'b0, wr_addr_o}, 256'd0);
    check("t5_rst_data", wr_data_o, 256'd0);
    tick();
    nrst       = 1'b0;
    wr_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    check("t5_no_write", 256'(q_addr.size()), 256'd0);
    check("t5_no_done", 256'(done_cnt - d0), 256'd0);
    do_start(16'h0500);
    send_row(make_row(8'h33), 9'd32, 1'b1);
    wait_done(waited);
    check("t5_nwords", 256'(q_addr.size()), 256'd1);
    if (q_addr.size() > 0) begin
      check("t5_addr", {240'b0, q_addr[0]}, 256'h0500);
      check("t5_data", q_data[0], seq_word(8'h33));
    end
    q_addr.delete();
    q_data.delete();

    // Empty row with last, then an over-range count
    d0 = done_cnt;
    do_start(16'h0600);
    send_row(make_row(8'hEE), 9'd0, 1'b1);
    wait_done(waited);
    for (int c = 0; c < 3; c++) tick();
    check("t6_nwords", 256'(q_addr.size()), 256'd0);
    check("t6_done_once", 256'(done_cnt - d0), 256'd1);

    do_start(16'h0700);
    send_row(make_row(8'h00), 9'd300, 1'b1);
    wait_done(waited);
    check("t6_clamp_nwords", 256'(q_addr.size()), 256'd8);
    for (int k = 0; k < 8 && k < q_addr.size(); k++) begin
      check("t6_clamp_data", q_data[k], seq_word(8'(32 * k)));
    end
    if (q_addr.size() > 7) check("t6_clamp_addr7", {240'b0, q_addr[7]}, 256'h0707);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mm_output_packer.md
Name: mm_output_packer

Overview:
- Downstream stage of mm_output_aligner.
- Takes leftmost-aligned matmul output rows, each carrying a variable number of valid elements, and concatenates them densely into fixed-width activation-buffer write words.
- Issues each word with an auto-incrementing address over a valid/ready write port.
- Handles partial-word flush on the final row of a tile and signals completion.

Parameters:
- elementBits, 8, bits per element
- numElements, 256, elements per input row (aligner output width)
- wordElements, 32, elements per activation-buffer write word; must divide numElements
- addrWidth, 16, write address width

Ports:
- clk  input  1  clock, all state on rising edge
- nrst  input  1  reset, asynchronous, active-high (1 = reset)
- start_i  input  1  begin a tile; honoured only in IDLE
- base_addr_i  input  addrWidth  first write address, sampled with start_i
- valid_i  input  1  input row valid
- ready_o  output  1  packer accepts row this cycle
- data_i  input  numElements*elementBits  aligned row; element 0 leftmost
- count_i  input  $clog2(numElements)+1  number of valid leading elements; values >numElements are clamped to numElements
- last_i  input  1  row is final of tile; sampled on accept
- wr_valid_o  output  1  write word valid
- wr_ready_i  input  1  buffer accepts word
- wr_addr_o  output  addrWidth  write address
- wr_data_o  output  wordElements*elementBits  write word; element 0 in lowest slice
- done_o  output  1  one-cycle pulse at tile completion

Behaviour:
- State: IDLE, RUN, FLUSH.
- Staging buffer: wordElements+numElements-1 elements.
- fill: count of buffered elements.
- addr: current write address.
- Reset, async on nrst=1:
  - state=IDLE, fill=0, addr=0, buffer=0.
  - All outputs 0: ready_o, wr_valid_o, done_o, wr_addr_o, wr_data_o.
  - Any in-flight tile is discarded; a new start_i is required.
- IDLE:
  - ready_o=0, wr_valid_o=0.
  - start_i=1 loads addr=base_addr_i, fill=0, then moves to RUN.
- start_i outside IDLE: ignored.
- RUN:
  - ready_o = (fill < wordElements).
  - Row accepted on valid_i && ready_o: elements data_i[0..count-1] are written to buffer[fill..fill+count-1], and fill += count.
  - If last_i=1 on accept, go to FLUSH next cycle.
  - wr_valid_o = (fill >= wordElements).
- FLUSH:
  - ready_o=0.
  - wr_valid_o = (fill > 0).
  - If fill < wordElements, wr_data_o presents buffer[0..fill-1] and zeros in the remaining slots.
- Write transfer, on wr_valid_o && wr_ready_i:
  - Buffer shifts down by wordElements; vacated slots are zero.
  - fill = max(fill - wordElements, 0).
  - addr increments by 1, wrapping modulo 2^addrWidth.
- Completion:
  - In FLUSH with fill==0 at cycle start, done_o=1 for exactly that cycle.
  - Next state is IDLE.
- Accept and emit are mutually exclusive by construction:
  - Accept requires fill<wordElements.
  - Emit in RUN requires fill>=wordElements.
  - Both are decided on the registered fill, so there is no simultaneous case.
- Output timing:
  - wr_addr_o and wr_data_o are driven from registers (buffer head, addr).
  - They hold stable while wr_valid_o=1 and wr_ready_i=0.
  - wr_valid_o never drops without a transfer.
  - wr_data_o value is don't-care when wr_valid_o=0.
- Latency: row accepted at cycle t gives its first word valid at t+1 (if it completes a word).
- Throughput: one word per cycle under continuous wr_ready_i.
- count_i=0 rows are legal. They are accepted, change no data, and may carry last_i.
- last_i with fill==0 after accept: FLUSH emits nothing; done_o fires on the next cycle.

Test Plan:
- start_i, base 0x0100; one row count=256, last_i=1, wr_ready_i=1 → 8 words at 0x0100..0x0107 carrying elements 0-31, 32-63, …; done_o pulses 1 cycle after the 8th transfer; state returns to IDLE.
- Rows count=20, 20, 24 (last on third), distinct element patterns:
  - word@base = rowA[0..19] ++ rowB[0..11];
  - word@base+1 = rowB[12..19] ++ rowC[0..23];
  - ready_o=0 in each cycle where fill≥32;
  - done_o pulses after the second write.
- One row count=40, last_i=1 → word0 = elements 0-31; word1 = elements 32-39 followed by 24 zero elements; exactly 2 writes.
- Backpressure: wr_ready_i=0 for 5 cycles mid-tile → wr_valid_o held high, wr_addr_o/wr_data_o unchanged, ready_o=0; no word lost or duplicated after release.
- Reset during FLUSH with fill=40 → all outputs 0 the same cycle; after release, no writes occur until start_i; a new tile starts at the new base_addr_i.
- start_i then single row count=0, last_i=1 → zero writes; done_o pulses exactly once; count_i=300 on another tile is treated as 256.
